// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the HI/LO registers.
//   Long ops (MULT/MULTU/DIV/DIVU) latch their operands and run for a fixed
//   number of cycles before writing HI/LO; MTHI/MTLO write in a single cycle.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        request from the E-stage decoder (op/a/b valid while high)
//   op[2:0]      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   a, b         forwarded rs / rt
//   busy         long operation in flight
//   stall        busy, or a long op being requested this cycle
//   hi, lo       architectural HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t     state;
    md_req_t    req_q;
    logic [3:0] cnt;

    logic        is_long;
    logic        sgn_mul, sgn_div;
    logic [63:0] prod;
    logic [31:0] dvd, dvs, quo, rem;
    logic [31:0] res_hi, res_lo;

    assign busy    = (state == RUN);
    assign is_long = (op <= 3'd3);
    assign stall   = busy | (start & is_long);

    // Result is a pure function of the latched request, so input changes
    // after acceptance cannot leak into the write-back.
    always_comb begin
        sgn_mul = (req_q.op == 3'd0);
        sgn_div = (req_q.op == 3'd2);
        // Sign-extend for MULT; the low 64 bits of a 64x64 product equal
        // the 32x32 signed product.
        prod = {{32{sgn_mul & req_q.a[31]}}, req_q.a} *
               {{32{sgn_mul & req_q.b[31]}}, req_q.b};
        // Signed divide done on magnitudes. 0x80000000 negates to itself,
        // which is the correct unsigned magnitude, so INT_MIN / -1 falls out
        // as quotient 0x80000000, remainder 0 without a special case.
        dvd = (sgn_div && req_q.a[31]) ? -req_q.a : req_q.a;
        dvs = (sgn_div && req_q.b[31]) ? -req_q.b : req_q.b;
        quo = '0;
        rem = '0;
        if (dvs != '0) begin
            quo = dvd / dvs;
            rem = dvd % dvs;
        end
        res_hi = '0;
        res_lo = '0;
        case (req_q.op)
            3'd0, 3'd1: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            3'd2, 3'd3: begin
                if (req_q.b == '0) begin
                    res_hi = req_q.a;
                    res_lo = '1;
                end else begin
                    res_lo = (sgn_div && (req_q.a[31] ^ req_q.b[31])) ? -quo : quo;
                    res_hi = (sgn_div && req_q.a[31]) ? -rem : rem;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_long) begin
                            req_q <= '{op: op, a: a, b: b};
                            cnt   <= op[1] ? DIV_CNT : MULT_CNT;
                            state <= RUN;
                        end else if (op == 3'd4) begin
                            hi <= a;
                        end else if (op == 3'd5) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    // Any start seen here, including on the completion
                    // edge, is dropped; stall keeps the instruction held.
                    if (cnt == 4'd1) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have these parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU, legal range 1..15.
- DIV_CYCLES, 10, busy duration of DIV/DIVU, legal range 1..15.

REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  clock; rising edge only.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request from the E-stage decoder; op, a and b are valid while it is high.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- busy  out  1  long operation in flight.
- stall  out  1  combinational: busy OR (start AND op<=3); drives the hazard unit.
- hi  out  32  HI register; MFHI reads it and the result goes to the EtoM aluout path.
- lo  out  32  LO register; MFLO reads it the same way.

Function
REQ-003 The block SHALL sit in the E stage; hi and lo are registered outputs, read combinationally by MFHI/MFLO.
REQ-004 FSM SHALL have two states, IDLE and RUN; busy=1 exactly in RUN.
REQ-005 In IDLE, a rising edge with start=1 and op in 0..3 SHALL:
- latch op, a and b;
- load the counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3);
- enter RUN.
REQ-006 In RUN, each edge SHALL decrement the 4-bit counter; on the edge where it holds 1, the block SHALL write hi/lo, clear the counter and return to IDLE.
REQ-007 Latency: start sampled at edge T -> busy=1 during cycles T+1..T+N, hi/lo carry the new value after edge T+N, busy=0 in cycle T+N+1.
REQ-008 The result SHALL be computed from the latched operands only; changes on a/b/op after edge T have no effect.
REQ-009 MULT SHALL form the signed 64-bit product of a and b, with {hi,lo} = product.
REQ-010 MULTU SHALL form the same product with both operands unsigned.
REQ-011 DIV SHALL give lo = signed quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-012 DIVU SHALL give the unsigned quotient and remainder.
REQ-013 A divisor of 0 SHALL give lo=32'hFFFFFFFF and hi=a, for both DIV and DIVU.
REQ-014 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-015 In IDLE, start=1 with op=4 SHALL write hi<=a on that edge, and op=5 SHALL write lo<=a; the FSM stays IDLE and busy stays 0.
REQ-016 start=1 with op 6/7 SHALL be ignored: no state change, and stall=busy.
REQ-017 start=1 while in RUN (any op) SHALL be ignored: no latch, no MTHI/MTLO write, counter unaffected; the hazard unit keeps the instruction stalled via stall.
REQ-018 A start presented on the same edge that RUN completes SHALL be ignored; it is accepted on the following edge, once the FSM is back in IDLE.
REQ-019 hi/lo SHALL change only on a RUN completion edge, an accepted MTHI/MTLO edge, or reset.

Reset
REQ-020 While reset=1 at a clock edge, the block SHALL:
- set hi=0, lo=0 and busy=0;
- clear the counter and the latched op/a/b;
- enter IDLE;
- ignore start.
REQ-021 Reset asserted mid-RUN SHALL discard the pending result: hi/lo stay 0 after the reset edge and no late write-back occurs.
REQ-022 Reset SHALL take priority over every other event on the same edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- MULT a=32'hFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- MULTU a=32'hFFFFFFFF, b=2 -> hi=32'h00000001, lo=32'hFFFFFFFE.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> busy 10 cycles, then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100; DIV 32'h80000000 by -1 -> lo=32'h80000000, hi=0.
- MTHI a=32'h12345678 while idle -> hi updates the next edge and busy never rises; MTLO issued during RUN -> lo unchanged, and the final lo is the multiply result.
- Reset asserted 3 cycles into a DIV -> busy=0 and hi=lo=0 after the reset edge, and both stay 0 for the next 10 cycles with start=0.
